energy_regulator: RTL and testbench

ENERGY_REGULATOR -- requirements
Module: energy_regulator

---
 rtl/energy_regulator_pkg.sv | 31 +++
 rtl/energy_rate_limiter.sv | 32 +++
 rtl/energy_regulator.sv | 135 +++++++++++++
 tb/tb_energy_regulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/energy_regulator_pkg.sv
// Shared constants, limits and types for the energy regulator.
// Holds default parameter values and accumulator saturation helpers.
package energy_regulator_pkg;

    // Default configuration of the regulator.
    localparam int ACC_W_DEF        = 4;
    localparam int RATE_DIV_DEF     = 4;
    localparam int DECAY_PERIOD_DEF = 64;

    // Saturation limits of the default-width accumulator.
    localparam int ACC_MAX_DEF = (1 << (ACC_W_DEF - 1)) - 1;
    localparam int ACC_MIN_DEF = -(1 << (ACC_W_DEF - 1));

    // Direction of a request or of an emitted pulse.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_INC  = 2'd1,
        DIR_DEC  = 2'd2
    } dir_e;

    // Largest value of a signed accumulator of width w.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value of a signed accumulator of width w.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/energy_rate_limiter.sv
// Cooldown counter that spaces output pulses at least RATE_DIV cycles apart.
// Ports: clk, rst (sync, active-high), emit (pulse issued this edge), emit_ok (cooldown is 0).
module energy_rate_limiter
    import energy_regulator_pkg::*;
#(
    parameter int RATE_DIV = RATE_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic emit,
    output logic emit_ok
);

    // One extra bit keeps the width >= 1 when RATE_DIV is 1.
    localparam int CD_W = $clog2(RATE_DIV + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(RATE_DIV - 1);

    logic [CD_W-1:0] cooldown;

    assign emit_ok = (cooldown == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cooldown <= '0;
        end else if (emit) begin
            cooldown <= CD_LOAD;
        end else if (cooldown != '0) begin
            cooldown <= cooldown - 1'b1;
        end
    end

endmodule

// File: rtl/energy_regulator.sv
// Turns raise/lower requests into rate-limited one-cycle energy pulses.
// Ports: clk, rst (sync, active-high), state_controller_inc/dec (requests),
//        energy_inc/energy_dec (registered pulses).
// Optional macro ENERGY_DECAY_EN adds an idle-driven decay pulse.
module energy_regulator
    import energy_regulator_pkg::*;
#(
    parameter int ACC_W        = ACC_W_DEF,
    parameter int RATE_DIV     = RATE_DIV_DEF,
    parameter int DECAY_PERIOD = DECAY_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic state_controller_inc,
    input  logic state_controller_dec,
    output logic energy_inc,
    output logic energy_dec
);

    // Two guard bits so acc +/- 2 never overflows before clamping.
    localparam int SW = ACC_W + 2;

    localparam logic signed [SW-1:0] P_ONE   = SW'(1);
    localparam logic signed [SW-1:0] M_ONE   = SW'(-1);
    localparam logic signed [SW-1:0] LIM_MAX = SW'(sat_max(ACC_W));
    localparam logic signed [SW-1:0] LIM_MIN = SW'(sat_min(ACC_W));

    if (ACC_W < 2 || RATE_DIV < 1 || DECAY_PERIOD < 2) begin : g_bad_cfg
        $error("energy_regulator: invalid parameter set");
    end

    logic signed [ACC_W-1:0] acc;
    logic signed [SW-1:0]    acc_ext;
    logic signed [SW-1:0]    req_delta;
    logic signed [SW-1:0]    emit_corr;
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    sum_sat;

    dir_e req_dir;
    dir_e emit_dir;
    logic acc_pos;
    logic acc_neg;
    logic emit_ok;
    logic emit_any;
    logic decay_fire;

    assign acc_neg = acc[ACC_W-1];
    assign acc_pos = !acc[ACC_W-1] && (acc != '0);

    // Both or neither request cancel out.
    always_comb begin
        unique case (1'b1)
            (state_controller_inc && !state_controller_dec): req_dir = DIR_INC;
            (state_controller_dec && !state_controller_inc): req_dir = DIR_DEC;
            default:                                         req_dir = DIR_NONE;
        endcase
    end

    // Direction follows the sign of the accumulator before this edge.
    always_comb begin
        unique case (1'b1)
            (emit_ok && acc_pos): emit_dir = DIR_INC;
            (emit_ok && acc_neg): emit_dir = DIR_DEC;
            default:              emit_dir = DIR_NONE;
        endcase
    end

    always_comb begin
        req_delta = '0;
        emit_corr = '0;
        if (req_dir == DIR_INC) req_delta = P_ONE;
        if (req_dir == DIR_DEC) req_delta = M_ONE;
        // An emitted pulse retires one unit of pending demand.
        if (emit_dir == DIR_INC) emit_corr = M_ONE;
        if (emit_dir == DIR_DEC) emit_corr = P_ONE;
    end

    assign acc_ext = {{2{acc[ACC_W-1]}}, acc};
    assign sum     = acc_ext + req_delta + emit_corr;

    always_comb begin
        sum_sat = sum;
        if (sum > LIM_MAX) sum_sat = LIM_MAX;
        if (sum < LIM_MIN) sum_sat = LIM_MIN;
    end

`ifdef ENERGY_DECAY_EN
    // Idle counter never needs to exceed DECAY_PERIOD-1.
    localparam int IDLE_W = $clog2(DECAY_PERIOD);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DECAY_PERIOD - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_edge;

    assign idle_edge  = (acc == '0) && (req_dir == DIR_NONE);
    assign decay_fire = idle_edge && emit_ok && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (decay_fire || !idle_edge) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign decay_fire = 1'b0;
`endif

    assign emit_any = (emit_dir != DIR_NONE) || decay_fire;

    energy_rate_limiter #(
        .RATE_DIV (RATE_DIV)
    ) u_rate (
        .clk     (clk),
        .rst     (rst),
        .emit    (emit_any),
        .emit_ok (emit_ok)
    );

    // Decay pulses leave the accumulator untouched; they only fire at acc 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            energy_inc <= 1'b0;
            energy_dec <= 1'b0;
        end else begin
            acc        <= sum_sat[ACC_W-1:0];
            energy_inc <= (emit_dir == DIR_INC);
            energy_dec <= (emit_dir == DIR_DEC) || decay_fire;
        end
    end

endmodule

// File: tb/tb_energy_regulator.sv
// Directed and random checks of energy_regulator against an integer model.
// Decay behaviour is checked according to ENERGY_DECAY_EN.
module tb_energy_regulator;

    localparam int ACC_W = 4;
    localparam int RATE_DIV = 4;
    localparam int DECAY_PERIOD = 64;
    localparam int AMAX = (1 << (ACC_W - 1)) - 1;
    localparam int AMIN = -(1 << (ACC_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sc_inc = 1'b0;
    logic sc_dec = 1'b0;
    logic energy_inc;
    logic energy_dec;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural reference state.
    int m_acc = 0;
    int m_cd = 0;
    int m_idle = 0;
    logic m_inc = 1'b0;
    logic m_dec = 1'b0;

    // Observed pulse bookkeeping.
    int n_inc = 0;
    int n_dec = 0;
    int inc_at[$];
    int dec_at[$];

    energy_regulator #(
        .ACC_W        (ACC_W),
        .RATE_DIV     (RATE_DIV),
        .DECAY_PERIOD (DECAY_PERIOD)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .state_controller_inc (sc_inc),
        .state_controller_dec (sc_dec),
        .energy_inc           (energy_inc),
        .energy_dec           (energy_dec)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: one rising edge, written from the pulse rules.
    task automatic model_edge(input logic r, input logic i, input logic d);
        int delta;
        int nxt;
        bit ready;
        bit up;
        bit dn;
        bit idle_edge;
        bit decay;
        if (r) begin
            m_acc = 0;
            m_cd = 0;
            m_idle = 0;
            m_inc = 1'b0;
            m_dec = 1'b0;
            return;
        end
        delta = (i && !d) ? 1 : ((d && !i) ? -1 : 0);
        ready = (m_cd == 0);
        up = ready && (m_acc > 0);
        dn = ready && (m_acc < 0);
        idle_edge = (m_acc == 0) && (delta == 0);
        decay = 1'b0;
`ifdef ENERGY_DECAY_EN
        decay = idle_edge && ready && (m_idle == DECAY_PERIOD - 1);
        if (decay || !idle_edge) m_idle = 0;
        else if (m_idle < DECAY_PERIOD - 1) m_idle = m_idle + 1;
`endif
        m_inc = up;
        m_dec = dn || decay;
        nxt = m_acc + delta - (up ? 1 : 0) + (dn ? 1 : 0);
        if (nxt > AMAX) nxt = AMAX;
        if (nxt < AMIN) nxt = AMIN;
        m_acc = nxt;
        if (up || dn || decay) m_cd = RATE_DIV - 1;
        else if (m_cd > 0) m_cd = m_cd - 1;
    endtask

    task automatic step(input logic r, input logic i, input logic d);
        rst = r;
        sc_inc = i;
        sc_dec = d;
        @(posedge clk);
        model_edge(r, i, d);
        #1;
        cyc++;
        chk_bit("energy_inc", energy_inc, m_inc);
        chk_bit("energy_dec", energy_dec, m_dec);
        chk_bit("exclusive", energy_inc && energy_dec, 1'b0);
        if (energy_inc === 1'b1) begin
            n_inc++;
            inc_at.push_back(cyc);
        end
        if (energy_dec === 1'b1) begin
            n_dec++;
            dec_at.push_back(cyc);
        end
    endtask

    task automatic clear_counts();
        n_inc = 0;
        n_dec = 0;
        inc_at.delete();
        dec_at.delete();
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b1);
        clear_counts();
    endtask

    initial begin
        int rst_cyc;
        int bias;

        // Reset with both requests high, then quiet cycles.
        do_reset(3);
        chk_bit("rst_inc", energy_inc, 1'b0);
        chk_bit("rst_dec", energy_dec, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
        chk_int("post_rst_pulses", n_inc + n_dec, 0);

        // Single request: pulse registered on the following edge.
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        chk_bit("single_n", energy_inc, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_bit("single_n1", energy_inc, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
        chk_int("single_inc_cnt", n_inc, 1);
        chk_int("single_dec_cnt", n_dec, 0);

        // Rate limit: three requests, three pulses 4 cycles apart.
        do_reset(1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) step(1'b0, 1'b0, 1'b0);
        chk_int("rate_inc_cnt", n_inc, 3);
        if (inc_at.size() == 3) begin
            chk_int("rate_gap0", inc_at[1] - inc_at[0], 4);
            chk_int("rate_gap1", inc_at[2] - inc_at[1], 4);
        end

        // Simultaneous requests cancel.
        do_reset(1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0);
        chk_int("simul_pulses", n_inc + n_dec, 0);

        // Saturation at the negative limit, then drain.
        do_reset(1);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b1);
        chk_int("sat_acc_model", m_acc, -8);
        chk_int("sat_hold_dec", n_dec, 10);
        if (dec_at.size() >= 2) begin
            chk_int("sat_gap", dec_at[dec_at.size()-1] - dec_at[dec_at.size()-2], 4);
        end
        clear_counts();
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b0);
        chk_int("sat_drain_dec", n_dec, 8);
        chk_int("sat_drain_inc", n_inc, 0);

        // Idle decay.
        do_reset(1);
        rst_cyc = cyc;
`ifdef ENERGY_DECAY_EN
        for (int k = 0; k < 70; k++) step(1'b0, 1'b0, 1'b0);
        chk_int("decay_cnt", n_dec, 1);
        if (dec_at.size() == 1) chk_int("decay_edge", dec_at[0] - rst_cyc, 64);
`else
        for (int k = 0; k < 200; k++) step(1'b0, 1'b0, 1'b0);
        chk_int("no_decay_cnt", n_dec + n_inc, 0);
        chk_int("no_decay_span", cyc - rst_cyc, 200);
`endif

        // Random traffic against the model, with occasional resets.
        do_reset(1);
        bias = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) bias = int'($urandom_range(0, 3));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) < bias,
                 $urandom_range(0, 3) < 3 - bias);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
